// File: rtl/sram_readout.sv
// sram_readout: reads a wrapped block of samples from an asynchronous SRAM, streams
// them on a valid/ready port and keeps a running sum/min/max of the emitted samples.
module sram_readout #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base,
  input  logic [ADDR_W:0]        len,
  output logic [ADDR_W-1:0]      address,
  input  logic [DATA_W-1:0]      sram_data,
  output logic                   nwr,
  output logic                   noe,
  output logic                   nce,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W+ADDR_W:0] sum,
  output logic [DATA_W-1:0]      smin,
  output logic [DATA_W-1:0]      smax,
  output logic                   busy,
  output logic                   done
);

  localparam int SUM_W = DATA_W + ADDR_W + 1;
  localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RD,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_cnt;
  logic [1:0]        r_wait;
  logic [ADDR_W-1:0] r_addr;
  logic              r_noe;
  logic              r_nce;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic [SUM_W-1:0]  r_sum;
  logic [DATA_W-1:0] r_smin;
  logic [DATA_W-1:0] r_smax;
  logic              r_busy;
  logic              r_done;

  logic [ADDR_W:0]   w_cnt_inc;

  // cnt is one bit wider than the address so a full-memory block can terminate.
  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_wait      <= '0;
      r_addr      <= '0;
      r_noe       <= 1'b1;
      r_nce       <= 1'b1;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_smin      <= '1;
      r_smax      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base  <= base;
            r_len   <= len;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_smin  <= '1;
            r_smax  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (r_len == '0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_addr  <= r_base;
            r_nce   <= 1'b0;
            r_noe   <= 1'b0;
            r_state <= S_RD;
          end
        end
        S_RD: begin
          r_wait  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Capture on the last latency cycle while the SRAM is still enabled.
          if (r_wait == LAST_WAIT) begin
            r_out_data  <= sram_data;
            r_out_valid <= 1'b1;
            r_nce       <= 1'b1;
            r_noe       <= 1'b1;
            r_state     <= S_HOLD;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_sum       <= r_sum + SUM_W'(r_out_data);
            if (r_out_data < r_smin) r_smin <= r_out_data;
            if (r_out_data > r_smax) r_smax <= r_out_data;
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == r_len) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_addr  <= r_base + w_cnt_inc[ADDR_W-1:0];
              r_nce   <= 1'b0;
              r_noe   <= 1'b0;
              r_state <= S_RD;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign address   = r_addr;
  assign nwr       = 1'b1;
  assign noe       = r_noe;
  assign nce       = r_nce;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign smin      = r_smin;
  assign smax      = r_smax;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_sram_readout.sv
// tb_sram_readout: runs an RD_LAT=1 and an RD_LAT=3 instance against an SRAM model
// and compares streamed data, addresses, stats and timing with a block-level model.
`timescale 1ns/1ps
module tb_sram_readout;

  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int SW    = DW + AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam int LOGN  = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst       [2];
  logic          start     [2];
  logic [AW-1:0] base      [2];
  logic [AW:0]   len       [2];
  logic [AW-1:0] address   [2];
  logic [DW-1:0] sram_data [2];
  logic          nwr       [2];
  logic          noe       [2];
  logic          nce       [2];
  logic [DW-1:0] out_data  [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [SW-1:0] sum       [2];
  logic [DW-1:0] smin      [2];
  logic [DW-1:0] smax      [2];
  logic          busy      [2];
  logic          done      [2];

  sram_readout #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut1 (
    .CLK(clk), .reset(rst[0]), .start(start[0]), .base(base[0]), .len(len[0]),
    .address(address[0]), .sram_data(sram_data[0]), .nwr(nwr[0]), .noe(noe[0]),
    .nce(nce[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .sum(sum[0]), .smin(smin[0]), .smax(smax[0]),
    .busy(busy[0]), .done(done[0])
  );

  sram_readout #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dut3 (
    .CLK(clk), .reset(rst[1]), .start(start[1]), .base(base[1]), .len(len[1]),
    .address(address[1]), .sram_data(sram_data[1]), .nwr(nwr[1]), .noe(noe[1]),
    .nce(nce[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .sum(sum[1]), .smin(smin[1]), .smax(smax[1]),
    .busy(busy[1]), .done(done[1])
  );

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // SRAM model: data appears RD_LAT cycles after an enabled address, junk otherwise.
  logic [DW-1:0] mem [DEPTH];
  logic          pen [2][3];
  logic [AW-1:0] pad [2][3];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      pen[d][0] <= (nce[d] === 1'b0) && (noe[d] === 1'b0);
      pad[d][0] <= address[d];
      for (int k = 1; k < 3; k++) begin
        pen[d][k] <= pen[d][k-1];
        pad[d][k] <= pad[d][k-1];
      end
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      sram_data[d] = 8'h5A;
      if (pen[d][2*d] === 1'b1) sram_data[d] = mem[pad[d][2*d]];
    end
  end

  // Monitor / consumer, one per instance.
  int            got_n      [2];
  int            addr_n     [2];
  int            done_n     [2];
  int            done_cyc   [2];
  int            viol       [2];
  int            stall_viol [2];
  int            stall_cnt  [2];
  int            stall_at   [2];
  int            rmode      [2];
  logic [DW-1:0] got_data   [2][LOGN];
  logic [AW-1:0] got_addr   [2][LOGN];
  logic          prev_valid [2];
  logic          prev_ready [2];
  logic          prev_nce   [2];
  logic [DW-1:0] prev_data  [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      got_n[d] = 0; addr_n[d] = 0; done_n[d] = 0; done_cyc[d] = 0;
      viol[d] = 0; stall_viol[d] = 0; stall_cnt[d] = 0;
      prev_valid[d] = 1'b0; prev_ready[d] = 1'b0; prev_nce[d] = 1'b1; prev_data[d] = '0;
      out_ready[d] = 1'b1;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rmode[d] != 2) stall_cnt[d] = 0;
      if (rmode[d] == 2 && out_valid[d] === 1'b1 && got_n[d] == stall_at[d] && stall_cnt[d] < 5) begin
        out_ready[d] = 1'b0;
        stall_cnt[d]++;
      end else if (rmode[d] == 1) begin
        out_ready[d] = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready[d] = 1'b1;
      end
      if (rst[d] === 1'b0) begin
        if (prev_valid[d] && !prev_ready[d] &&
            (out_valid[d] !== 1'b1 || out_data[d] !== prev_data[d])) stall_viol[d]++;
        if (nwr[d] !== 1'b1 || noe[d] !== nce[d] || (out_valid[d] === 1'b1 && nce[d] !== 1'b1))
          viol[d]++;
        if (nce[d] === 1'b0 && prev_nce[d] === 1'b1 && addr_n[d] < LOGN) begin
          got_addr[d][addr_n[d]] = address[d];
          addr_n[d]++;
        end
        if (out_valid[d] === 1'b1 && out_ready[d] && got_n[d] < LOGN) begin
          got_data[d][got_n[d]] = out_data[d];
          got_n[d]++;
        end
        if (done[d] === 1'b1) begin
          done_n[d]++;
          done_cyc[d] = cyc;
        end
      end
      prev_valid[d] = (out_valid[d] === 1'b1);
      prev_ready[d] = out_ready[d];
      prev_data[d]  = out_data[d];
      prev_nce[d]   = nce[d];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Starts a block and waits (bounded) for its done pulse; returns in the DONE cycle.
  task automatic run_burst(input int d, input int b, input int n, input int m,
                           output int s, output bit to);
    int dn0;
    dn0 = done_n[d];
    rmode[d] = m;
    base[d] = AW'(b);
    len[d] = (AW+1)'(n);
    start[d] = 1'b1;
    s = cyc;
    step(1);
    start[d] = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 30000; k++) begin
      if (done_n[d] != dn0) begin
        to = 1'b0;
        break;
      end
      step(1);
    end
  endtask

  task automatic test_reset(input int d);
    rst[d] = 1'b1;
    step(2);
    checks++;
    if ({address[d], nwr[d], noe[d], nce[d], out_data[d], out_valid[d], sum[d], smin[d], smax[d], busy[d], done[d]}
        !== {11'd0, 1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 20'd0, 8'hFF, 8'd0, 1'b0, 1'b0})
      $display("FAIL reset_state d%0d: got addr=%0d nce=%b noe=%b valid=%b sum=%0d smin=%0d smax=%0d busy=%b",
               d, address[d], nce[d], noe[d], out_valid[d], sum[d], smin[d], smax[d], busy[d]);
    if ({address[d], nwr[d], noe[d], nce[d], out_data[d], out_valid[d], sum[d], smin[d], smax[d], busy[d], done[d]}
        !== {11'd0, 1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 20'd0, 8'hFF, 8'd0, 1'b0, 1'b0}) errors++;
    rst[d] = 1'b0;
    step(3);
    checks++;
    if (busy[d] !== 1'b0 || nce[d] !== 1'b1 || done_n[d] != 0) begin
      errors++;
      $display("FAIL idle_after_reset d%0d: busy=%b nce=%b dones=%0d, want 0 1 0", d, busy[d], nce[d], done_n[d]);
    end
  endtask

  task automatic test_stream(input int d);
    int b, n, s, g0, a0, dn0, v0, bad;
    bit to;
    logic [SW-1:0] esum;
    logic [DW-1:0] emin, emax, ev;
    v0 = viol[d];
    for (int t = 0; t < 6; t++) begin
      if (t == 0) begin
        b = 0; n = 4;
        for (int i = 0; i < 4; i++) mem[i] = DW'(10 * (i + 1));
      end else if (t == 1) begin
        b = 2046; n = 4;
        mem[2046] = 8'd1; mem[2047] = 8'd2; mem[0] = 8'd3; mem[1] = 8'd4;
      end else begin
        b = $urandom_range(0, DEPTH - 1);
        n = $urandom_range(1, 40);
      end
      g0 = got_n[d]; a0 = addr_n[d]; dn0 = done_n[d];
      run_burst(d, b, n, 0, s, to);
      checks++;
      if (to) begin errors++; $display("FAIL stream_timeout d%0d: no done within bound, base=%0d len=%0d", d, b, n); end
      esum = '0; emin = '1; emax = '0; bad = 0;
      for (int i = 0; i < n; i++) begin
        ev = mem[(b + i) % DEPTH];
        esum += SW'(ev);
        if (ev < emin) emin = ev;
        if (ev > emax) emax = ev;
        if (got_data[d][g0 + i] !== ev || got_addr[d][a0 + i] !== AW'((b + i) % DEPTH)) begin
          bad++;
          $display("FAIL stream_item d%0d i=%0d: got data=%0d addr=%0d want data=%0d addr=%0d",
                   d, i, got_data[d][g0 + i], got_addr[d][a0 + i], ev, (b + i) % DEPTH);
        end
      end
      checks++;
      if (bad != 0) errors++;
      checks++;
      if ({sum[d], smin[d], smax[d]} !== {esum, emin, emax}) begin
        errors++;
        $display("FAIL stream_stats d%0d: got sum=%0d min=%0d max=%0d want %0d %0d %0d",
                 d, sum[d], smin[d], smax[d], esum, emin, emax);
      end
      checks++;
      if (got_n[d] - g0 != n || addr_n[d] - a0 != n) begin
        errors++;
        $display("FAIL stream_count d%0d: got samples=%0d reads=%0d want %0d", d, got_n[d] - g0, addr_n[d] - a0, n);
      end
      checks++;
      if (done_cyc[d] - s != 2 + n * (lat(d) + 2)) begin
        errors++;
        $display("FAIL stream_latency d%0d: got %0d cycles want %0d", d, done_cyc[d] - s, 2 + n * (lat(d) + 2));
      end
      checks++;
      if (busy[d] !== 1'b0) begin errors++; $display("FAIL busy_in_done d%0d: got %b want 0", d, busy[d]); end
      step(3);
      checks++;
      if (done_n[d] - dn0 != 1) begin
        errors++;
        $display("FAIL done_pulses d%0d: got %0d want 1", d, done_n[d] - dn0);
      end
    end
    checks++;
    if (viol[d] != v0) begin errors++; $display("FAIL strobes d%0d: got %0d bad cycles want 0", d, viol[d] - v0); end
  endtask

  task automatic test_len_zero(input int d);
    int s, g0, a0;
    bit to;
    g0 = got_n[d]; a0 = addr_n[d];
    run_burst(d, $urandom_range(0, DEPTH - 1), 0, 0, s, to);
    checks++;
    if (to || done_cyc[d] - s != 2) begin
      errors++;
      $display("FAIL len0_latency d%0d: got %0d cycles (timeout=%0d) want 2", d, done_cyc[d] - s, to);
    end
    checks++;
    if (addr_n[d] != a0 || got_n[d] != g0 || nce[d] !== 1'b1) begin
      errors++;
      $display("FAIL len0_access d%0d: got reads=%0d samples=%0d want 0 0", d, addr_n[d] - a0, got_n[d] - g0);
    end
    checks++;
    if ({sum[d], smin[d], smax[d]} !== {20'd0, 8'hFF, 8'd0}) begin
      errors++;
      $display("FAIL len0_stats d%0d: got sum=%0d min=%0d max=%0d want 0 255 0", d, sum[d], smin[d], smax[d]);
    end
    step(2);
  endtask

  task automatic test_backpressure(input int d);
    int b, n, s, g0, sv0, v0, bad;
    bit to;
    logic [SW-1:0] esum;
    for (int t = 0; t < 2; t++) begin
      b = $urandom_range(0, DEPTH - 1);
      n = (t == 0) ? 6 : 30;
      g0 = got_n[d]; sv0 = stall_viol[d]; v0 = viol[d];
      stall_at[d] = g0 + 1;
      run_burst(d, b, n, (t == 0) ? 2 : 1, s, to);
      checks++;
      if (to) begin errors++; $display("FAIL bp_timeout d%0d: no done, mode=%0d", d, t); end
      esum = '0; bad = 0;
      for (int i = 0; i < n; i++) begin
        esum += SW'(mem[(b + i) % DEPTH]);
        if (got_data[d][g0 + i] !== mem[(b + i) % DEPTH]) bad++;
      end
      checks++;
      if (bad != 0 || got_n[d] - g0 != n || sum[d] !== esum) begin
        errors++;
        $display("FAIL bp_sequence d%0d: got %0d wrong of %0d, sum=%0d want sum=%0d", d, bad, got_n[d] - g0, sum[d], esum);
      end
      checks++;
      if (stall_viol[d] != sv0 || viol[d] != v0) begin
        errors++;
        $display("FAIL bp_hold d%0d: got unstable=%0d strobe=%0d want 0 0", d, stall_viol[d] - sv0, viol[d] - v0);
      end
      if (t == 0) begin
        checks++;
        if (stall_cnt[d] != 5 || done_cyc[d] - s != 7 + n * (lat(d) + 2)) begin
          errors++;
          $display("FAIL bp_stall_timing d%0d: got stalls=%0d cycles=%0d want 5 %0d",
                   d, stall_cnt[d], done_cyc[d] - s, 7 + n * (lat(d) + 2));
        end
      end
      rmode[d] = 0;
      step(2);
    end
  endtask

  task automatic test_reset_mid(input int d);
    int b, s, g0, a0, dn0, bad;
    bit to;
    logic [SW-1:0] esum;
    b = $urandom_range(0, DEPTH - 1);
    g0 = got_n[d]; a0 = addr_n[d]; dn0 = done_n[d];
    rmode[d] = 0;
    base[d] = AW'(b); len[d] = 12'd8; start[d] = 1'b1;
    step(1);
    start[d] = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (addr_n[d] - a0 == 3) begin to = 1'b0; break; end
      step(1);
    end
    step(1);
    rst[d] = 1'b1;
    step(1);
    checks++;
    if (to || {nce[d], noe[d], out_valid[d], busy[d], done[d]} !== 5'b11000) begin
      errors++;
      $display("FAIL midreset_state d%0d: got nce=%b noe=%b valid=%b busy=%b done=%b (timeout=%0d) want 1 1 0 0 0",
               d, nce[d], noe[d], out_valid[d], busy[d], done[d], to);
    end
    rst[d] = 1'b0;
    step(6);
    checks++;
    if (done_n[d] != dn0 || busy[d] !== 1'b0 || got_n[d] - g0 != 2) begin
      errors++;
      $display("FAIL midreset_quiet d%0d: got dones=%0d busy=%b samples=%0d want 0 0 2", d, done_n[d] - dn0, busy[d], got_n[d] - g0);
    end
    b = $urandom_range(0, DEPTH - 1);
    g0 = got_n[d];
    run_burst(d, b, 5, 0, s, to);
    esum = '0; bad = 0;
    for (int i = 0; i < 5; i++) begin
      esum += SW'(mem[(b + i) % DEPTH]);
      if (got_data[d][g0 + i] !== mem[(b + i) % DEPTH]) bad++;
    end
    checks++;
    if (to || bad != 0 || sum[d] !== esum || done_cyc[d] - s != 2 + 5 * (lat(d) + 2)) begin
      errors++;
      $display("FAIL midreset_rerun d%0d: got wrong=%0d sum=%0d cycles=%0d want 0 %0d %0d",
               d, bad, sum[d], done_cyc[d] - s, esum, 2 + 5 * (lat(d) + 2));
    end
    step(2);
  endtask

  task automatic test_start_ignored(input int d);
    int b, n, s, g0, a0, dn0, bad;
    bit to;
    logic [SW-1:0] esum;
    b = $urandom_range(0, DEPTH - 1);
    n = 6;
    g0 = got_n[d]; a0 = addr_n[d]; dn0 = done_n[d];
    rmode[d] = 0;
    base[d] = AW'(b); len[d] = 12'(n); start[d] = 1'b1;
    s = cyc;
    step(1);
    start[d] = 1'b0;
    step(4);
    base[d] = AW'(b + 100); len[d] = 12'd3; start[d] = 1'b1;
    step(1);
    start[d] = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 500; k++) begin
      if (done_n[d] != dn0) begin to = 1'b0; break; end
      step(1);
    end
    start[d] = 1'b1;
    base[d] = AW'($urandom_range(0, DEPTH - 1)); len[d] = 12'd2;
    step(1);
    start[d] = 1'b0;
    checks++;
    if (busy[d] !== 1'b0) begin errors++; $display("FAIL start_in_done d%0d: got busy=%b want 0", d, busy[d]); end
    step(4);
    esum = '0; bad = 0;
    for (int i = 0; i < n; i++) begin
      esum += SW'(mem[(b + i) % DEPTH]);
      if (got_data[d][g0 + i] !== mem[(b + i) % DEPTH] || got_addr[d][a0 + i] !== AW'((b + i) % DEPTH)) bad++;
    end
    checks++;
    if (to || bad != 0 || got_n[d] - g0 != n || addr_n[d] - a0 != n) begin
      errors++;
      $display("FAIL start_while_busy d%0d: got wrong=%0d samples=%0d reads=%0d want 0 %0d %0d",
               d, bad, got_n[d] - g0, addr_n[d] - a0, n, n);
    end
    checks++;
    if (sum[d] !== esum || done_n[d] - dn0 != 1 || done_cyc[d] - s != 2 + n * (lat(d) + 2)) begin
      errors++;
      $display("FAIL start_ignored_stats d%0d: got sum=%0d dones=%0d cycles=%0d want %0d 1 %0d",
               d, sum[d], done_n[d] - dn0, done_cyc[d] - s, esum, 2 + n * (lat(d) + 2));
    end
  endtask

  task automatic test_full(input int d);
    int b, s, g0, a0, bad, dup;
    bit to;
    bit seen [DEPTH];
    logic [SW-1:0] esum;
    b = $urandom_range(0, DEPTH - 1);
    g0 = got_n[d]; a0 = addr_n[d];
    run_burst(d, b, DEPTH, 1, s, to);
    rmode[d] = 0;
    esum = '0; bad = 0; dup = 0;
    for (int i = 0; i < DEPTH; i++) seen[i] = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      esum += SW'(mem[(b + i) % DEPTH]);
      if (got_data[d][g0 + i] !== mem[(b + i) % DEPTH]) bad++;
      if (seen[got_addr[d][a0 + i]]) dup++;
      seen[got_addr[d][a0 + i]] = 1'b1;
    end
    checks++;
    if (to || got_n[d] - g0 != DEPTH || addr_n[d] - a0 != DEPTH || dup != 0) begin
      errors++;
      $display("FAIL full_coverage d%0d: got samples=%0d reads=%0d repeats=%0d want %0d %0d 0",
               d, got_n[d] - g0, addr_n[d] - a0, dup, DEPTH, DEPTH);
    end
    checks++;
    if (bad != 0 || sum[d] !== esum) begin
      errors++;
      $display("FAIL full_sum d%0d: got wrong=%0d sum=%0d want 0 %0d", d, bad, sum[d], esum);
    end
    step(2);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; base[d] = '0; len[d] = '0;
      rmode[d] = 0; stall_at[d] = 0;
    end
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    for (int d = 0; d < 2; d++) test_reset(d);
    for (int d = 0; d < 2; d++) test_stream(d);
    for (int d = 0; d < 2; d++) test_len_zero(d);
    for (int d = 0; d < 2; d++) test_backpressure(d);
    for (int d = 0; d < 2; d++) test_reset_mid(d);
    for (int d = 0; d < 2; d++) test_start_ignored(d);
    for (int d = 0; d < 2; d++) test_full(d);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
